// File: rtl/pad_vddio_mon_pkg.sv
// Shared definitions for the VDDIO pad-supply monitor.
//   state_e             : FSM state encoding, also driven on the STATE debug port
//   DEF_DEBOUNCE_CYCLES : default synced-high cycles before the rail is qualified
//   DEF_ISO_DELAY       : default cycles spent in ISO_RELEASE and in BROWNOUT
package pad_vddio_mon_pkg;

    typedef enum logic [2:0] {
        OFF         = 3'd0,
        DEBOUNCE    = 3'd1,
        ISO_RELEASE = 3'd2,
        ACTIVE      = 3'd3,
        BROWNOUT    = 3'd4
    } state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_ISO_DELAY       = 8;

endpackage

// File: rtl/pad_vddio_monitor_if.sv
// Signal bundle for the VDDIO monitor's supply/status connection.
//   vddio_sense  : raw supply-present level from the pad
//   irq_clr      : single-cycle brownout flag clear
//   pwr_good, iso_en, io_oe_en, brownout_irq, state : monitor status
// modport master : the side that drives the sense level and clears the flag
// modport slave  : the monitor side that reports status
interface pad_vddio_monitor_if;

    logic       vddio_sense;
    logic       irq_clr;
    logic       pwr_good;
    logic       iso_en;
    logic       io_oe_en;
    logic       brownout_irq;
    logic [2:0] state;

    modport master (
        output vddio_sense, irq_clr,
        input  pwr_good, iso_en, io_oe_en, brownout_irq, state
    );

    modport slave (
        input  vddio_sense, irq_clr,
        output pwr_good, iso_en, io_oe_en, brownout_irq, state
    );

endinterface

// File: rtl/pad_vddio_monitor_sync.sv
// Two-flop synchroniser for an asynchronous level; both flops reset to 0.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input level
//   q_o    : synchronised level (second flop)
module pad_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pad_vddio_monitor.sv
// VDDIO pad-supply monitor: qualifies the rail with a debounce period, releases
// pad isolation, then permits pad output enables; any low sample while qualified
// drops into a timed BROWNOUT before requalifying.
//   CLK          : block clock
//   RESETn       : asynchronous active-low reset
//   VDDIO_SENSE  : asynchronous supply-present level
//   PWR_GOOD     : rail qualified (ISO_RELEASE, ACTIVE)
//   ISO_EN       : pad-ring isolation enable
//   IO_OE_EN     : global pad output-enable permit
//   BROWNOUT_IRQ : sticky brownout flag
//   IRQ_CLR      : single-cycle flag clear
//   STATE        : current FSM state (debug)
// Optional feature: define PAD_VDDIO_MON_IRQ_EN to enable BROWNOUT_IRQ; otherwise
// it is tied 0 and IRQ_CLR is ignored.
module pad_vddio_monitor
    import pad_vddio_mon_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned ISO_DELAY       = DEF_ISO_DELAY
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       VDDIO_SENSE,
    output logic       PWR_GOOD,
    output logic       ISO_EN,
    output logic       IO_OE_EN,
    output logic       BROWNOUT_IRQ,
    input  logic       IRQ_CLR,
    output logic [2:0] STATE
);

    localparam int unsigned MAXC = (DEBOUNCE_CYCLES > ISO_DELAY) ? DEBOUNCE_CYCLES : ISO_DELAY;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ISO_LAST = CW'(ISO_DELAY - 1);

    logic          sense_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          iso_q, iso_d;
    logic          pg_q, pg_d;
    logic          oe_q, oe_d;

    pad_sync2 u_sync (
        .clk_i  (CLK),
        .rst_ni (RESETn),
        .d_i    (VDDIO_SENSE),
        .q_o    (sense_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            OFF: begin
                if (sense_s) begin
                    state_d = DEBOUNCE;
                    cnt_d   = '0;
                end
            end
            DEBOUNCE: begin
                if (!sense_s) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ISO_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ISO_RELEASE: begin
                if (!sense_s) begin
                    state_d = BROWNOUT;
                    cnt_d   = '0;
                end else if (cnt_q == ISO_LAST) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACTIVE: begin
                if (!sense_s) begin
                    state_d = BROWNOUT;
                    cnt_d   = '0;
                end
            end
            BROWNOUT: begin
                // Timed exit only; the sense level is deliberately ignored here.
                if (cnt_q == ISO_LAST) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they register on the same edge as
    // the state itself; OE is only ever set in ACTIVE, where ISO is cleared.
    always_comb begin
        iso_d = 1'b1;
        pg_d  = 1'b0;
        oe_d  = 1'b0;
        case (state_d)
            ISO_RELEASE: begin
                iso_d = 1'b0;
                pg_d  = 1'b1;
            end
            ACTIVE: begin
                iso_d = 1'b0;
                pg_d  = 1'b1;
                oe_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= OFF;
            cnt_q   <= '0;
            iso_q   <= 1'b1;
            pg_q    <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            iso_q   <= iso_d;
            pg_q    <= pg_d;
            oe_q    <= oe_d;
        end
    end

`ifdef PAD_VDDIO_MON_IRQ_EN
    logic irq_q, irq_d;

    // Set wins over clear when BROWNOUT is entered in the same cycle.
    always_comb begin
        irq_d = irq_q;
        if ((state_d == BROWNOUT) && (state_q != BROWNOUT)) begin
            irq_d = 1'b1;
        end else if (IRQ_CLR) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign BROWNOUT_IRQ = irq_q;
`else
    logic irq_clr_unused;
    assign irq_clr_unused = IRQ_CLR;
    assign BROWNOUT_IRQ   = 1'b0;
`endif

    assign PWR_GOOD = pg_q;
    assign ISO_EN   = iso_q;
    assign IO_OE_EN = oe_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_pad_vddio_monitor.sv
// Directed bench for pad_vddio_monitor (DEBOUNCE_CYCLES=4, ISO_DELAY=3) plus a
// second instance (1/1) for the isolation/output-enable invariant under random
// sense toggling. "Edge n" is the n-th rising CLK edge after RESETn release.
module tb_pad_vddio_monitor;
    import pad_vddio_mon_pkg::*;

`ifdef PAD_VDDIO_MON_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    pad_vddio_monitor_if bus ();
    pad_vddio_monitor_if bus2 ();

    pad_vddio_monitor #(.DEBOUNCE_CYCLES(4), .ISO_DELAY(3)) dut (
        .CLK          (clk),
        .RESETn       (rst_n),
        .VDDIO_SENSE  (bus.vddio_sense),
        .PWR_GOOD     (bus.pwr_good),
        .ISO_EN       (bus.iso_en),
        .IO_OE_EN     (bus.io_oe_en),
        .BROWNOUT_IRQ (bus.brownout_irq),
        .IRQ_CLR      (bus.irq_clr),
        .STATE        (bus.state)
    );

    pad_vddio_monitor #(.DEBOUNCE_CYCLES(1), .ISO_DELAY(1)) dut_min (
        .CLK          (clk),
        .RESETn       (rst_n),
        .VDDIO_SENSE  (bus2.vddio_sense),
        .PWR_GOOD     (bus2.pwr_good),
        .ISO_EN       (bus2.iso_en),
        .IO_OE_EN     (bus2.io_oe_en),
        .BROWNOUT_IRQ (bus2.brownout_irq),
        .IRQ_CLR      (bus2.irq_clr),
        .STATE        (bus2.state)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves RESETn released on a falling edge, so the next rising edge is edge 1.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.vddio_sense  = 1'b0;
        bus.irq_clr      = 1'b0;
        bus2.vddio_sense = 1'b0;
        bus2.irq_clr     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.vddio_sense = 1'b1;
        bus.irq_clr     = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (bus.state !== 3'd0 || bus.iso_en !== 1'b1 || bus.pwr_good !== 1'b0 ||
            bus.io_oe_en !== 1'b0 || bus.brownout_irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: state=%0d iso=%b pg=%b oe=%b irq=%b, want 0 1 0 0 0",
                     bus.state, bus.iso_en, bus.pwr_good, bus.io_oe_en, bus.brownout_irq);
        end
    endtask

    task automatic test_powerup();
        int unsigned st [10] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 3};
        logic [9:0] iso = 10'b0000111111; // bit e-1 = value after edge e
        logic [9:0] pg  = 10'b1111000000;
        logic [9:0] oe  = 10'b1000000000;
        do_reset();
        bus.vddio_sense = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            n_cmp++;
            if (bus.state !== 3'(st[e-1]) || bus.iso_en !== iso[e-1] ||
                bus.pwr_good !== pg[e-1] || bus.io_oe_en !== oe[e-1]) begin
                n_err++;
                $display("FAIL powerup_e%0d: state=%0d iso=%b pg=%b oe=%b, want %0d %b %b %b",
                         e, bus.state, bus.iso_en, bus.pwr_good, bus.io_oe_en,
                         st[e-1], iso[e-1], pg[e-1], oe[e-1]);
            end
        end
    endtask

    task automatic test_glitch();
        int unsigned st [14] = '{0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 2, 2, 2, 3};
        do_reset();
        bus.vddio_sense = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step();
            if (e == 3) bus.vddio_sense = 1'b0;
            if (e == 4) bus.vddio_sense = 1'b1;
            n_cmp++;
            if (bus.state !== 3'(st[e-1]) || bus.io_oe_en !== (e == 14)) begin
                n_err++;
                $display("FAIL glitch_e%0d: state=%0d oe=%b, want %0d %b",
                         e, bus.state, bus.io_oe_en, st[e-1], (e == 14));
            end
        end
    endtask

    task automatic test_brownout();
        int unsigned st [7] = '{3, 3, 4, 4, 4, 0, 1};
        logic [6:0] iso = 7'b1111100;     // bit i = value after edge k+i
        logic [6:0] oe  = 7'b0000011;
        logic [6:0] irq;
        irq = IRQ_ON ? 7'b1111100 : 7'b0000000;
        do_reset();
        bus.vddio_sense = 1'b1;
        repeat (10) step();
        bus.vddio_sense = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 2) bus.vddio_sense = 1'b1;
            n_cmp++;
            if (bus.state !== 3'(st[i]) || bus.iso_en !== iso[i] ||
                bus.io_oe_en !== oe[i] || bus.pwr_good !== oe[i] ||
                bus.brownout_irq !== irq[i]) begin
                n_err++;
                $display("FAIL brownout_k+%0d: state=%0d iso=%b oe=%b pg=%b irq=%b, want %0d %b %b %b %b",
                         i, bus.state, bus.iso_en, bus.io_oe_en, bus.pwr_good, bus.brownout_irq,
                         st[i], iso[i], oe[i], oe[i], irq[i]);
            end
        end
    endtask

    task automatic test_irq_clear();
        do_reset();
        bus.vddio_sense = 1'b1;
        repeat (10) step();
        bus.vddio_sense = 1'b0;
        step();
        step();
        bus.irq_clr = 1'b1;
        step();
        n_cmp++;
        if (bus.state !== 3'(BROWNOUT) || bus.brownout_irq !== IRQ_ON) begin
            n_err++;
            $display("FAIL irq_race_set: state=%0d irq=%b, want 4 %b",
                     bus.state, bus.brownout_irq, IRQ_ON);
        end
        step();
        bus.irq_clr = 1'b0;
        n_cmp++;
        if (bus.brownout_irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_clear: irq=%b, want 0", bus.brownout_irq);
        end
        step();
        n_cmp++;
        if (bus.brownout_irq !== 1'b0 || bus.state !== 3'(BROWNOUT)) begin
            n_err++;
            $display("FAIL irq_stays_clear: irq=%b state=%0d, want 0 4",
                     bus.brownout_irq, bus.state);
        end
    endtask

    task automatic test_midop_reset();
        do_reset();
        bus.vddio_sense = 1'b1;
        repeat (8) step();
        n_cmp++;
        if (bus.state !== 3'(ISO_RELEASE)) begin
            n_err++;
            $display("FAIL midrst_pre: state=%0d, want 2", bus.state);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.state !== 3'd0 || bus.iso_en !== 1'b1 || bus.pwr_good !== 1'b0 ||
            bus.io_oe_en !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_async: state=%0d iso=%b pg=%b oe=%b, want 0 1 0 0",
                     bus.state, bus.iso_en, bus.pwr_good, bus.io_oe_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 2 || e == 7 || e == 9 || e == 10) begin
                n_cmp++;
                if (bus.io_oe_en !== (e == 10) || bus.iso_en !== (e < 7)) begin
                    n_err++;
                    $display("FAIL midrst_requal_e%0d: oe=%b iso=%b, want %b %b",
                             e, bus.io_oe_en, bus.iso_en, (e == 10), (e < 7));
                end
            end
        end
    endtask

    task automatic test_invariant();
        logic seen_active = 1'b0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step();
            bus2.vddio_sense = ($urandom_range(0, 3) != 0);
            if (bus2.state == 3'(ACTIVE)) seen_active = 1'b1;
            n_cmp++;
            assert (!(bus2.io_oe_en && bus2.iso_en))
            else begin
                n_err++;
                $display("FAIL invariant_c%0d: oe=%b iso=%b, want not both 1",
                         i, bus2.io_oe_en, bus2.iso_en);
            end
        end
        n_cmp++;
        if (seen_active !== 1'b1) begin
            n_err++;
            $display("FAIL invariant_reach_active: seen=%b, want 1", seen_active);
        end
    endtask

    initial begin
        bus.vddio_sense  = 1'b0;
        bus.irq_clr      = 1'b0;
        bus2.vddio_sense = 1'b0;
        bus2.irq_clr     = 1'b0;
        test_reset();
        test_powerup();
        test_glitch();
        test_brownout();
        test_irq_clear();
        test_midop_reset();
        test_invariant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pad_vddio_monitor.md
PAD_VDDIO_MONITOR -- requirements
Module: pad_vddio_monitor

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive synced-high cycles needed before power is declared good; legal range 1 or more.
REQ-002 SHALL have parameter ISO_DELAY, default 8: cycles spent in ISO_RELEASE and in BROWNOUT; legal range 1 or more.
REQ-003 SHALL have port CLK  input  1  single clock for the whole block.
REQ-004 SHALL have port RESETn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port VDDIO_SENSE  input  1  asynchronous level from the VDDIO supply pad; 1 means the rail is present.
REQ-006 SHALL have port PWR_GOOD  output  1  high while the rail is qualified (ISO_RELEASE, ACTIVE).
REQ-007 SHALL have port ISO_EN  output  1  pad-ring isolation enable, high means isolated.
REQ-008 SHALL have port IO_OE_EN  output  1  global pad output-enable permit.
REQ-009 SHALL have port BROWNOUT_IRQ  output  1  sticky brownout flag.
REQ-010 SHALL have port IRQ_CLR  input  1  single-cycle clear for BROWNOUT_IRQ.
REQ-011 SHALL have port STATE  output  3  current FSM state encoding, for debug.

Function
REQ-012 SHALL synchronise VDDIO_SENSE through two flops; the second flop output is sense_s, and all FSM decisions use only sense_s.
REQ-013 SHALL implement FSM states OFF, DEBOUNCE, ISO_RELEASE, ACTIVE and BROWNOUT, with one shared counter cnt.
REQ-014 OFF: on sense_s=1, go to DEBOUNCE with cnt=0; otherwise remain in OFF.
REQ-015 DEBOUNCE, sense_s=1: if cnt==DEBOUNCE_CYCLES-1, go to ISO_RELEASE with cnt=0; else cnt+1. DEBOUNCE therefore lasts exactly DEBOUNCE_CYCLES cycles.
REQ-016 DEBOUNCE, sense_s=0: go to OFF with cnt=0. A glitch restarts qualification from scratch.
REQ-017 ISO_RELEASE, sense_s=1: if cnt==ISO_DELAY-1, go to ACTIVE; else cnt+1.
REQ-018 ISO_RELEASE or ACTIVE, sense_s=0: go to BROWNOUT with cnt=0, on the first low cycle with no filtering.
REQ-019 BROWNOUT: stay for exactly ISO_DELAY cycles regardless of sense_s, then go to OFF.
REQ-020 Outputs SHALL be registered and update on the same edge as the state.
- OFF, DEBOUNCE, BROWNOUT: ISO_EN=1, PWR_GOOD=0, IO_OE_EN=0.
- ISO_RELEASE: ISO_EN=0, PWR_GOOD=1, IO_OE_EN=0.
- ACTIVE: ISO_EN=0, PWR_GOOD=1, IO_OE_EN=1.
REQ-021 IO_OE_EN=1 with ISO_EN=1 SHALL never occur in any cycle.
REQ-022 cnt width SHALL be the clog2 of the larger of DEBOUNCE_CYCLES and ISO_DELAY, minimum 1 bit; it never wraps.
REQ-023 Latency: with VDDIO_SENSE high and stable before edge 1, ISO_EN falls after edge 2+1+DEBOUNCE_CYCLES, and IO_OE_EN rises ISO_DELAY edges later.

Reset
REQ-024 RESETn low SHALL asynchronously force: state OFF, cnt=0, both sync flops 0, ISO_EN=1, PWR_GOOD=0, IO_OE_EN=0, BROWNOUT_IRQ=0, STATE=OFF encoding.
REQ-025 Reset asserted mid-operation in any state SHALL take effect immediately, with no completion of BROWNOUT timing.
REQ-026 After RESETn deassertion the block SHALL restart from OFF and requalify the rail.

Configuration
REQ-027 With PAD_VDDIO_MON_IRQ_EN defined:
- BROWNOUT_IRQ sets on the edge that enters BROWNOUT.
- It clears on an IRQ_CLR=1 cycle.
- A simultaneous set and clear leaves it set.
REQ-028 Without PAD_VDDIO_MON_IRQ_EN: BROWNOUT_IRQ is tied 0, IRQ_CLR is ignored, and both ports are retained.

Structure
REQ-029 Package pad_vddio_mon_pkg SHALL hold the state enum (3 bits: OFF=0, DEBOUNCE=1, ISO_RELEASE=2, ACTIVE=3, BROWNOUT=4) and the default parameter constants.
REQ-030 The synchroniser SHALL be a separate sub-module, pad_sync2 (2-flop, reset to 0); all other logic stays in pad_vddio_monitor.

Verification (DEBOUNCE_CYCLES=4, ISO_DELAY=3 unless stated)
REQ-031 Power-up: VDDIO_SENSE high before edge 1 -> DEBOUNCE after edge 3, ISO_EN=0/PWR_GOOD=1 after edge 7, IO_OE_EN=1 after edge 10.
REQ-032 Glitch: sense drops for one synced cycle while cnt=2 in DEBOUNCE -> OFF next edge; the full 4-cycle qualification restarts; IO_OE_EN stays 0 throughout.
REQ-033 Brownout: in ACTIVE, sense falls before edge k -> BROWNOUT after edge k+2 with IO_OE_EN=0 and ISO_EN=1 on that edge; OFF after edge k+5; with the macro, BROWNOUT_IRQ=1 after edge k+2.
REQ-034 IRQ clear race: IRQ_CLR=1 on the same edge as BROWNOUT entry -> BROWNOUT_IRQ=1; IRQ_CLR=1 one edge later -> BROWNOUT_IRQ=0; without the macro, BROWNOUT_IRQ stays 0.
REQ-035 Mid-operation reset: RESETn pulsed low between edges while in ISO_RELEASE -> ISO_EN=1 and PWR_GOOD=0 before the next edge, STATE=0; after release with sense high, IO_OE_EN rises after edge 10 again.
REQ-036 Invariant: an assertion that IO_OE_EN and ISO_EN are never both 1 SHALL be checked over randomised sense toggling with DEBOUNCE_CYCLES=1 and ISO_DELAY=1.
